multi_debounce: RTL

Parametrised multi-channel debouncer for mechanical keys, switches and other slow, noisy board inputs. It generalises the team's single-line jitter filter in four ways: configurable channel count, stability window and synchroniser depth; restart-on-glitch filtering; rise/fall event pulses; and a long-press (hold) flag. It sits directly behind the board key/switch pins and feeds control FSMs, which consume either the clean levels or the one-cycle edge pulses.

---
 rtl/multi_debounce.sv | 126 ++++++++++++
 1 files changed

// File: rtl/multi_debounce.sv
`default_nettype none
// ============================================================================
// Module   : multi_debounce
// Brief    : Per-channel synchroniser, restart-on-glitch debouncer with
//            rise/fall event pulses and a long-press hold flag.
// Revision : 1.0 - initial release
// ============================================================================
module multi_debounce #(
  parameter int   CH          = 4,
  parameter int   DELAY       = 100000,
  parameter int   CNT_W       = 20,
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0,
  parameter int   HOLD        = 50000000,
  parameter int   HOLD_W      = 32
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] dout,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic [CH-1:0] hold,
  output logic [CH-1:0] busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(DELAY - 1);
  localparam logic [HOLD_W-1:0] c_hold_max = HOLD_W'(HOLD);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_dout;
    logic                   w_dout_nxt;
    logic                   r_rise;
    logic                   w_rise_nxt;
    logic                   r_fall;
    logic                   w_fall_nxt;
    logic [HOLD_W-1:0]      r_hcnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_sync <= {SYNC_STAGES{RST_VAL}};
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], din[i]};
      end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_dout  <= RST_VAL;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_dout  <= w_dout_nxt;
        r_rise  <= w_rise_nxt;
        r_fall  <= w_fall_nxt;
      end
    end

    // Any return to the accepted level while checking restarts the window.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_dout_nxt  = r_dout;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s != r_dout) begin
            w_state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_s == r_dout) begin
            w_state_nxt = ST_IDLE;
          end else if (r_cnt == c_cnt_last) begin
            w_state_nxt = ST_IDLE;
            w_dout_nxt  = w_s;
            w_rise_nxt  = w_s;
            w_fall_nxt  = ~w_s;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    // Clearing on the next dout value lets hold drop in the same cycle dout falls.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_hcnt <= '0;
      end else if (!w_dout_nxt) begin
        r_hcnt <= '0;
      end else if (r_dout && (r_hcnt != c_hold_max)) begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end

    assign dout[i] = r_dout;
    assign rise[i] = r_rise;
    assign fall[i] = r_fall;
    assign hold[i] = (r_hcnt == c_hold_max);
    assign busy[i] = (r_state == ST_CHECK);
  end

endmodule
`default_nettype wire
